// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, latches opcode and
// ALU flags, and runs a timed ready/request handshake with data memory.
module cu_multicycle #(
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned OP_W   = 2,
  parameter int unsigned MEM_TO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             zf_i,
  input  logic             sf_i,
  input  logic             cf_i,
  input  logic             mem_ready_i,
  output logic [OP_W-1:0]  op_o,
  output logic             ir_en_o,
  output logic             pc_en_o,
  output logic             pc_load_o,
  output logic             imm_sel_o,
  output logic             st_sel_o,
  output logic             reg_en_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [2:0]       flags_o,
  output logic             halted_o,
  output logic             err_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TO + 1);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef struct packed {
    logic ir_en;
    logic pc_en;
    logic pc_load;
    logic imm_sel;
    logic st_sel;
    logic reg_en;
    logic mem_req;
    logic mem_we;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [3:0]       opc_q, opc_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             halted_q, halted_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_c;

  // Only the low nibble is ever architecturally meaningful; wider opcodes just flag illegal.
  if (OPC_W > 4) begin : g_ext
    assign illegal_c = |opcode_i[OPC_W-1:4];
  end else begin : g_base
    assign illegal_c = 1'b0;
  end

  function automatic logic is_alu(input logic [3:0] o);
    return (o[3:2] != 2'b11) && (o != 4'b0011);
  endfunction

  function automatic logic is_wb(input logic [3:0] o);
    return ((o[3:2] == 2'b01) && (o != 4'b0100)) ||
           ((o[3:2] == 2'b10) && (o != 4'b1000));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RST;
      opc_q    <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Next state, then outputs registered from the next state so they track state_q exactly.
  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    flags_d  = flags_q;
    cnt_d    = '0;
    err_d    = err_q;
    halted_d = 1'b0;
    ctrl_d   = '0;

    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        opc_d = opcode_i[3:0];
        if (illegal_c) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_alu(opc_q)) flags_d = {cf_i, sf_i, zf_i};
        case (opc_q)
          4'b0011, 4'b1110: state_d = S_FETCH;
          4'b1100, 4'b1101: state_d = S_MEM;
          4'b1111:          state_d = S_HALT;
          default:          state_d = is_wb(opc_q) ? S_WB : S_FETCH;
        endcase
      end
      S_MEM: begin
        // Ready wins over a coincident timeout.
        if (mem_ready_i) begin
          state_d = (opc_q == 4'b1100) ? S_WB : S_FETCH;
        end else if (cnt_q == CNT_W'(MEM_TO - 1)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase

    halted_d = (state_d == S_HALT);
    case (state_d)
      S_FETCH: begin
        ctrl_d.ir_en = 1'b1;
        ctrl_d.pc_en = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.imm_sel = (opc_d[3:2] == 2'b01);
        ctrl_d.pc_load = (opc_d == 4'b1110) ||
                         ((opc_d == 4'b0011) && !flags_d[0] && !flags_d[1]);
      end
      S_MEM: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.st_sel  = (opc_d == 4'b1101);
        ctrl_d.mem_we  = (opc_d == 4'b1101);
      end
      S_WB:    ctrl_d.reg_en = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  assign op_o      = opc_q[OP_W-1:0];
  assign ir_en_o   = ctrl_q.ir_en;
  assign pc_en_o   = ctrl_q.pc_en;
  assign pc_load_o = ctrl_q.pc_load;
  assign imm_sel_o = ctrl_q.imm_sel;
  assign st_sel_o  = ctrl_q.st_sel;
  assign reg_en_o  = ctrl_q.reg_en;
  assign mem_req_o = ctrl_q.mem_req;
  assign mem_we_o  = ctrl_q.mem_we;
  assign flags_o   = flags_q;
  assign halted_o  = halted_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_cu_multicycle.sv
// Bench for cu_multicycle: instruction-level reference model predicts every cycle's outputs.
module tb_cu_multicycle;

  localparam int unsigned OPC_W  = 6;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned MEM_TO = 15;

  localparam logic [7:0] EN_IR  = 8'b1000_0000;
  localparam logic [7:0] EN_PC  = 8'b0100_0000;
  localparam logic [7:0] EN_PCL = 8'b0010_0000;
  localparam logic [7:0] EN_IMM = 8'b0001_0000;
  localparam logic [7:0] EN_ST  = 8'b0000_1000;
  localparam logic [7:0] EN_REG = 8'b0000_0100;
  localparam logic [7:0] EN_REQ = 8'b0000_0010;
  localparam logic [7:0] EN_WE  = 8'b0000_0001;

  logic             clk = 1'b0;
  logic             rst;
  logic [OPC_W-1:0] opcode_i;
  logic             zf_i, sf_i, cf_i, mem_ready_i;
  logic [OP_W-1:0]  op_o;
  logic             ir_en_o, pc_en_o, pc_load_o, imm_sel_o, st_sel_o, reg_en_o;
  logic             mem_req_o, mem_we_o, halted_o, err_o;
  logic [2:0]       flags_o;
  logic [14:0]      act;

  int n_vec = 0;
  int n_bad = 0;
  int n_instr = 0;

  // Model state: architectural view only (latched opcode nibble, flags, fault, halt).
  logic [3:0] m_opc = '0;
  logic [2:0] m_flags = '0;
  logic       m_err = 1'b0;
  logic       m_halt = 1'b0;

  cu_multicycle #(.OPC_W(OPC_W), .OP_W(OP_W), .MEM_TO(MEM_TO)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .zf_i(zf_i), .sf_i(sf_i), .cf_i(cf_i),
    .mem_ready_i(mem_ready_i), .op_o(op_o), .ir_en_o(ir_en_o), .pc_en_o(pc_en_o),
    .pc_load_o(pc_load_o), .imm_sel_o(imm_sel_o), .st_sel_o(st_sel_o), .reg_en_o(reg_en_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .flags_o(flags_o), .halted_o(halted_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  assign act = {op_o, ir_en_o, pc_en_o, pc_load_o, imm_sel_o, st_sel_o, reg_en_o,
                mem_req_o, mem_we_o, flags_o, halted_o, err_o};

  function automatic logic [14:0] ev(input logic [7:0] en, input logic h);
    return {m_opc[1:0], en, m_flags, h, m_err};
  endfunction

  // One clock: drive inputs, compare at the falling edge, advance past the rising edge.
  task automatic cyc(input string nm, input logic [14:0] exp, input logic chk, input logic r,
                     input logic [OPC_W-1:0] opc, input logic rdy, input logic [2:0] alu);
    rst = r;
    opcode_i = opc;
    mem_ready_i = rdy;
    {cf_i, sf_i, zf_i} = alu;
    @(negedge clk);
    if (chk) begin
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s (instr %0d): got %h want %h", nm, n_instr, act, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL pin %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [OPC_W-1:0] rop();
    return OPC_W'($urandom);
  endfunction

  // k: MEM cycle on which mem_ready rises (outside 1..MEM_TO means never).
  // rst_at: MEM cycle on which rst is driven (0 means never).
  task automatic do_instr(input logic [OPC_W-1:0] o, input int k, input int rst_at,
                          input logic [2:0] alu_e);
    logic [3:0] lo;
    logic [7:0] en;
    logic       st;
    logic       rdy;
    lo = o[3:0];
    n_instr++;
    cyc("fetch", ev(EN_IR | EN_PC, 1'b0), 1'b1, 1'b0, rop(), 1'($urandom), 3'($urandom));
    cyc("decode", ev(8'h00, 1'b0), 1'b1, 1'b0, o, 1'($urandom), 3'($urandom));
    m_opc = lo;
    if (|o[OPC_W-1:4]) begin
      m_err = 1'b1;
      m_halt = 1'b1;
      return;
    end
    en = 8'h00;
    if (lo[3:2] == 2'b01) en = en | EN_IMM;
    if (lo == 4'b1110 || (lo == 4'b0011 && m_flags[1:0] == 2'b00)) en = en | EN_PCL;
    cyc("exec", ev(en, 1'b0), 1'b1, 1'b0, rop(), 1'($urandom), alu_e);
    if (lo[3:2] != 2'b11 && lo != 4'b0011) m_flags = alu_e;
    if (lo == 4'b1111) begin
      m_halt = 1'b1;
      return;
    end
    if (lo == 4'b1100 || lo == 4'b1101) begin
      st = (lo == 4'b1101);
      en = st ? (EN_REQ | EN_ST | EN_WE) : EN_REQ;
      for (int i = 1; i <= int'(MEM_TO); i++) begin
        if (i == rst_at) begin
          cyc("mem_at_rst", ev(en, 1'b0), 1'b1, 1'b1, rop(), 1'($urandom), 3'($urandom));
          m_opc = '0;
          m_flags = '0;
          m_err = 1'b0;
          cyc("rst_idle", ev(8'h00, 1'b0), 1'b1, 1'b0, rop(), 1'($urandom), 3'($urandom));
          return;
        end
        rdy = (i == k);
        cyc("mem", ev(en, 1'b0), 1'b1, 1'b0, rop(), rdy, 3'($urandom));
        if (rdy) begin
          if (!st) cyc("wb_ld", ev(EN_REG, 1'b0), 1'b1, 1'b0, rop(), 1'($urandom), 3'($urandom));
          return;
        end
      end
      m_err = 1'b1;
      m_halt = 1'b1;
      return;
    end
    if (((lo[3:2] == 2'b01) && lo != 4'b0100) || ((lo[3:2] == 2'b10) && lo != 4'b1000))
      cyc("wb", ev(EN_REG, 1'b0), 1'b1, 1'b0, rop(), 1'($urandom), 3'($urandom));
  endtask

  task automatic halt_rst();
    repeat (3) cyc("halt", ev(8'h00, 1'b1), 1'b1, 1'b0, rop(), 1'($urandom), 3'($urandom));
    cyc("halt_rst", ev(8'h00, 1'b1), 1'b1, 1'b1, rop(), 1'($urandom), 3'($urandom));
    m_opc = '0;
    m_flags = '0;
    m_err = 1'b0;
    m_halt = 1'b0;
    cyc("rst_idle", ev(8'h00, 1'b0), 1'b1, 1'b0, rop(), 1'($urandom), 3'($urandom));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OPC_W-1:0] o;
    int k, ra;
    rst = 1'b1;
    opcode_i = '0;
    mem_ready_i = 1'b0;
    {cf_i, sf_i, zf_i} = 3'b000;
    @(posedge clk);
    #1;
    cyc("rst0", ev(8'h00, 1'b0), 1'b0, 1'b1, rop(), 1'b0, 3'b000);
    cyc("rst_hold", ev(8'h00, 1'b0), 1'b1, 1'b1, rop(), 1'b1, 3'b111);
    cyc("rst_idle", ev(8'h00, 1'b0), 1'b1, 1'b0, rop(), 1'b1, 3'b111);

    // Writeback ALU then register compare.
    do_instr(6'b00_1010, 0, 0, 3'b010);
    do_instr(6'b00_0001, 0, 0, 3'b101);
    pin("flags_after_cmp", {5'b0, flags_o}, 8'h05);

    // JGT taken, then not taken after a zf=1 compare.
    do_instr(6'b00_0000, 0, 0, 3'b100);
    do_instr(6'b00_0011, 0, 0, 3'b111);
    do_instr(6'b00_0000, 0, 0, 3'b001);
    do_instr(6'b00_0011, 0, 0, 3'b000);
    do_instr(6'b00_1110, 0, 0, 3'b000);
    pin("flags_kept_by_jumps", {5'b0, flags_o}, 8'h01);

    // Store completing on the third MEM cycle, immediate ops.
    do_instr(6'b00_1101, 3, 0, 3'b000);
    do_instr(6'b00_0101, 0, 0, 3'b110);
    do_instr(6'b00_0100, 0, 0, 3'b011);

    // Load with ready on the timeout cycle completes without a fault.
    do_instr(6'b00_1100, int'(MEM_TO), 0, 3'b000);
    pin("ld_ready_at_timeout", {6'b0, halted_o, err_o}, 8'h00);

    // Load that never completes times out.
    do_instr(6'b00_1100, 0, 0, 3'b000);
    pin("ld_timeout", {5'b0, halted_o, err_o, mem_req_o}, 8'h06);
    halt_rst();

    // Illegal wide opcode, then HALT opcode.
    do_instr(6'b01_0001, 0, 0, 3'b000);
    pin("illegal_halt", {6'b0, halted_o, err_o}, 8'h03);
    halt_rst();
    do_instr(6'b00_1111, 0, 0, 3'b000);
    pin("halt_op", {6'b0, halted_o, err_o}, 8'h02);
    halt_rst();

    // Reset during the second MEM cycle of a load.
    do_instr(6'b00_0110, 0, 0, 3'b111);
    do_instr(6'b00_1100, 5, 2, 3'b000);
    pin("flags_after_mid_rst", {5'b0, flags_o}, 8'h00);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 99);
      if (k < 3) o = 6'({2'($urandom_range(1, 3)), 4'($urandom)});
      else if (k < 5) o = 6'b00_1111;
      else if (k < 30) o = 6'({2'b00, 2'b11, 1'b0, 1'($urandom)});
      else o = 6'({2'b00, 4'($urandom)});
      k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(MEM_TO - 1, MEM_TO + 1))
                                      : int'($urandom_range(1, 5));
      ra = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_instr(o, k, ra, 3'($urandom));
      if (m_halt) halt_rst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Parametrised multi-cycle control unit for the 5-bit CPU family, the sequencing successor to the single-cycle combinational decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states, latches the opcode and ALU flags internally, and runs a ready/request handshake with data memory that includes a timeout. It sits between the instruction register, ALU, register file, PC and data memory, and drives all of their enables.

## Interface
- OPC_W, 4, opcode width (≥4). Any set bit above bit 3 is an illegal opcode.
- OP_W, 2, ALU operation select width. The low OP_W opcode bits are passed through.
- MEM_TO, 15, maximum number of cycles spent waiting for mem_ready before a fault (≥1).
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- opcode  in  OPC_W  instruction register opcode. Valid from DECODE onward.
- zf, sf, cf  in  1 each  ALU flags, sampled at the end of EXEC.
- mem_ready  in  1  data memory completion strobe.
- op  out  OP_W  ALU operation = opc_q[OP_W-1:0].
- ir_en  out  1  instruction register load.
- pc_en  out  1  PC increment.
- pc_load  out  1  load PC from the jump target. Replaces the old JMP_SEL.
- imm_sel  out  1  select the immediate operand.
- st_sel  out  1  store-path select.
- reg_en  out  1  register-file write enable.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write.
- flags  out  3  {cf,sf,zf} latched.
- halted  out  1  the FSM is in HALT.
- err  out  1  fault: illegal opcode or memory timeout.

## Operation
- The opcode is latched into opc_q at the end of DECODE.
- Instruction classes, decided on opc_q[3:0]:
  - 00xx except 0011: register compare. Flags are updated, no writeback.
  - 0011: JGT. Taken when flags_q.zf=0 and flags_q.sf=0.
  - 0100: immediate compare. No writeback.
  - 01xx other than 0100: immediate ALU with writeback.
  - 1000: register ALU, no writeback.
  - 10xx other than 1000: register ALU with writeback.
  - 1100: LD (indirect).
  - 1101: ST (indirect).
  - 1110: JMP, unconditional.
  - 1111: HALT.
- FETCH: ir_en=1 and pc_en=1 for one cycle, then → DECODE.
- DECODE: one cycle. An illegal opcode (upper bits set) goes to HALT with err=1. Otherwise → EXEC.
- EXEC:
  - op is driven. imm_sel=1 for the 01 class.
  - ALU classes (00 except 0011, 01, 10): flags_q ← {cf,sf,zf} at the end of EXEC.
  - Writeback ops → WB. Non-writeback ops → FETCH.
  - JGT/JMP: pc_load=1 in EXEC if taken, then → FETCH. Flags are unchanged.
  - LD/ST → MEM.
  - HALT opcode → HALT with err=0.
- MEM:
  - mem_req=1. st_sel=mem_we=1 for ST.
  - The wait counter starts at 0 on entry and increments each cycle mem_ready=0.
  - mem_ready=1: LD → WB, ST → FETCH.
  - Counter reaches MEM_TO with mem_ready still 0: → HALT with err=1, and mem_req drops next cycle.
- WB: reg_en=1 for one cycle, then → FETCH.
- HALT: absorbing. All enables are 0 and halted=1. Only rst exits.
- Outputs are decoded from state and opc_q. They are glitch-free with respect to the opcode input outside DECODE.

## Timing
- Reset: the state goes to FETCH on the cycle after rst is sampled high. opc_q=0, flags_q=0, counter=0, err=0.
- Output values during rst and in the first reset cycle: op=0 and every enable, halted and err 0.
- rst mid-operation, including during MEM with mem_req high: mem_req drops the cycle after rst is sampled. No WB or pc_load pulse follows.
- Latency:
  - Writeback ALU: 4 cycles.
  - Compare or jump: 3 cycles.
  - ST: 3 + k cycles, where k ≥ 1 is the number of MEM cycles.
  - LD: 4 + k cycles.
- mem_ready is sampled only in MEM and ignored in every other state.
- mem_ready arriving in the same cycle as the timeout takes priority: the access completes with no fault.
- JGT evaluates flags latched by an earlier instruction. An immediately preceding compare is visible because its flags are latched at the end of its EXEC.
- The wait counter width is clog2(MEM_TO+1). It never wraps.

## Test plan
- Reset, then 1010 followed by 0001: 1010 gives states F,D,E,W with reg_en high in cycle 4 only. 0001 gives reg_en=0 and flags latched.
- Compare setting zf=0, sf=0, then 0011: pc_load=1 in EXEC. Repeat with zf=1: pc_load stays 0 and the sequence returns to FETCH after 3 cycles.
- 1101 with mem_ready after 3 cycles: mem_req and mem_we high for exactly 3 MEM cycles, reg_en never asserted, then FETCH.
- 1100 with mem_ready never asserted, MEM_TO=15: after 15 MEM cycles halted=1, err=1, mem_req=0, and the state stays there until rst.
- OPC_W=6, opcode 010001: HALT with err=1. Separately, 1111 gives halted=1 with err=0.
- rst asserted in the second MEM cycle of an LD: mem_req falls the next cycle, no reg_en pulse, and FETCH resumes with flags=0.
